// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory read bus between the fetch stage and memory.
//            Request/acknowledge handshake: the master raises req with a
//            stable addr, and the slave answers with ack and data.
// Signals  : req   master->slave  read request
//            addr  master->slave  read address (ADDR_WIDTH)
//            ack   slave->master  read data valid
//            data  slave->master  read data (DATA_WIDTH)
// Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) ();
    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  ack;
    logic [DATA_WIDTH-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage ahead of the sequence control matrix.
//            Holds the PC and a single-entry return-address register, applies
//            the sequencer's PC strobes, and runs a req/ack instruction-memory
//            read on i_ir_ld, latching the result into the IR.
// Ports    : clk          system clock, rising edge
//            rst_n        asynchronous active-low reset
//            i_pc_rst     synchronous PC clear (highest priority)
//            i_pc_ld      load PC from source selected by i_pc_src
//            i_pc_inc     PC <= PC + WORD_SIZE (lowest priority)
//            i_pc_src     00 PC+WORD_SIZE, 01 branch, 10 stack, 11 zero
//            i_bra_src    0 relative (PC + signed IR[7:0]), 1 absolute
//            i_stk_ld     stack <= PC + WORD_SIZE (pre-update PC)
//            i_ir_ld      fetch request strobe
//            mem          instruction-memory bus (master side)
//            o_ir         instruction register
//            o_ir_valid   one-cycle pulse when IR is reloaded
//            o_pc         program counter
//            o_busy       fetch in progress
//            o_fetch_err  sticky: fetch timeout or i_ir_ld while waiting
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int WORD_SIZE  = 1,
    parameter int MAX_WAIT   = 15
) (
    input  wire                   clk,
    input  wire                   rst_n,
    input  wire                   i_pc_rst,
    input  wire                   i_pc_inc,
    input  wire                   i_pc_ld,
    input  wire [1:0]             i_pc_src,
    input  wire                   i_bra_src,
    input  wire                   i_stk_ld,
    input  wire                   i_ir_ld,
    fetch_unit_if.master          mem,
    output logic [DATA_WIDTH-1:0] o_ir,
    output logic                  o_ir_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_busy,
    output logic                  o_fetch_err
);

    localparam logic [ADDR_WIDTH-1:0] c_word      = ADDR_WIDTH'(WORD_SIZE);
    localparam logic [7:0]            c_wait_last = 8'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc,     w_pc_nxt;
    logic [ADDR_WIDTH-1:0] r_stk,    w_stk_nxt;
    logic [DATA_WIDTH-1:0] r_ir,     w_ir_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
    logic                  r_req,    w_req_nxt;
    logic                  r_valid,  w_valid_nxt;
    logic                  r_busy,   w_busy_nxt;
    logic                  r_err,    w_err_nxt;
    logic [7:0]            r_cnt,    w_cnt_nxt;

    logic [ADDR_WIDTH-1:0] w_pc_plus;
    logic [ADDR_WIDTH-1:0] w_bra_target;

    // Branch target always comes from the registered IR, never from
    // data still in flight on the memory bus.
    assign w_pc_plus    = r_pc + c_word;
    assign w_bra_target = i_bra_src ? ADDR_WIDTH'(r_ir[7:0])
                                    : r_pc + ADDR_WIDTH'($signed(r_ir[7:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_stk   <= '0;
            r_ir    <= '0;
            r_addr  <= '0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_stk   <= w_stk_nxt;
            r_ir    <= w_ir_nxt;
            r_addr  <= w_addr_nxt;
            r_req   <= w_req_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_stk_nxt   = r_stk;
        w_ir_nxt    = r_ir;
        w_addr_nxt  = r_addr;
        w_req_nxt   = r_req;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        // PC update; everything reads the pre-update PC and stack, so a
        // same-cycle stack load plus PC_Src=10 swaps cleanly.
        if (i_pc_rst) begin
            w_pc_nxt = '0;
        end else if (i_pc_ld) begin
            case (i_pc_src)
                2'b00:   w_pc_nxt = w_pc_plus;
                2'b01:   w_pc_nxt = w_bra_target;
                2'b10:   w_pc_nxt = r_stk;
                default: w_pc_nxt = '0;
            endcase
        end else if (i_pc_inc) begin
            w_pc_nxt = w_pc_plus;
        end

        if (i_stk_ld) begin
            w_stk_nxt = w_pc_plus;
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                // DONE accepts a new request directly for back-to-back fetch.
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                if (i_ir_ld) begin
                    w_addr_nxt  = r_pc;
                    w_req_nxt   = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_ir_ld) begin
                    w_err_nxt = 1'b1;
                end
                // Ack is tested before the timeout so a last-cycle ack wins.
                if (mem.ack) begin
                    w_ir_nxt    = mem.data;
                    w_req_nxt   = 1'b0;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_wait_last) begin
                    w_req_nxt   = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem.req     = r_req;
    assign mem.addr    = r_addr;
    assign o_ir        = r_ir;
    assign o_ir_valid  = r_valid;
    assign o_pc        = r_pc;
    assign o_busy      = r_busy;
    assign o_fetch_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Directed scenarios followed
//            by randomized strobes, all compared cycle by cycle against a
//            transaction-level reference model of the PC, stack and fetch.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int WS = 1;
    localparam int MW = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pc_rst, pc_inc, pc_ld, bra_src, stk_ld, ir_ld;
    logic [1:0] pc_src;
    logic [DW-1:0] ir;
    logic          ir_valid, busy, fetch_err;
    logic [AW-1:0] pc;

    fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    fetch_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORD_SIZE(WS), .MAX_WAIT(MW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pc_rst   (pc_rst),
        .i_pc_inc   (pc_inc),
        .i_pc_ld    (pc_ld),
        .i_pc_src   (pc_src),
        .i_bra_src  (bra_src),
        .i_stk_ld   (stk_ld),
        .i_ir_ld    (ir_ld),
        .mem        (mem_bus),
        .o_ir       (ir),
        .o_ir_valid (ir_valid),
        .o_pc       (pc),
        .o_busy     (busy),
        .o_fetch_err(fetch_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pc, m_stk, m_ir, m_addr, m_waited;
    bit m_pending, m_done, m_err;

    function automatic void m_reset();
        m_pc = 0; m_stk = 0; m_ir = 0; m_addr = 0; m_waited = 0;
        m_pending = 0; m_done = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        int opc = m_pc;
        int rel;
        if (pc_rst) m_pc = 0;
        else if (pc_ld) begin
            case (pc_src)
                2'd0: m_pc = (opc + WS) % 256;
                2'd1: begin
                    rel = m_ir % 256;
                    if (bra_src) m_pc = rel;
                    else begin
                        if (rel > 127) rel = rel - 256;
                        m_pc = (opc + rel + 256) % 256;
                    end
                end
                2'd2: m_pc = m_stk;
                default: m_pc = 0;
            endcase
        end else if (pc_inc) m_pc = (opc + WS) % 256;
        if (stk_ld) m_stk = (opc + WS) % 256;

        if (m_pending) begin
            if (ir_ld) m_err = 1;
            if (mem_bus.ack) begin
                m_ir = int'(mem_bus.data); m_pending = 0; m_done = 1;
            end else if (m_waited + 1 == MW) begin
                m_pending = 0; m_err = 1;
            end else m_waited++;
        end else begin
            m_done = 0;
            if (ir_ld) begin
                m_addr = opc; m_pending = 1; m_waited = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check("pc",    32'(pc),           32'(m_pc));
        check("ir",    32'(ir),           32'(m_ir));
        check("addr",  32'(mem_bus.addr), 32'(m_addr));
        check("req",   32'(mem_bus.req),  32'(m_pending));
        check("busy",  32'(busy),         32'(m_pending | m_done));
        check("valid", 32'(ir_valid),     32'(m_done));
        check("err",   32'(fetch_err),    32'(m_err));
    endtask

    // One clock cycle: drive inputs, step the model at the edge, sample at +1.
    task automatic cyc(input bit r, input bit inc, input bit ld, input bit [1:0] src,
                       input bit bra, input bit stk, input bit irl, input bit ack,
                       input bit [15:0] data);
        pc_rst = r; pc_inc = inc; pc_ld = ld; pc_src = src; bra_src = bra;
        stk_ld = stk; ir_ld = irl; mem_bus.ack = ack; mem_bus.data = data;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic set_pc(input int v);
        cyc(1, 0, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k < v; k++) cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'h0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic do_reset();
        pc_rst = 0; pc_inc = 0; pc_ld = 0; pc_src = 0; bra_src = 0;
        stk_ld = 0; ir_ld = 0; mem_bus.ack = 0; mem_bus.data = '0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_pc",    32'(pc),           32'h0);
        check("rst_ir",    32'(ir),           32'h0);
        check("rst_req",   32'(mem_bus.req),  32'h0);
        check("rst_addr",  32'(mem_bus.addr), 32'h0);
        check("rst_valid", 32'(ir_valid),     32'h0);
        check("rst_busy",  32'(busy),         32'h0);
        check("rst_err",   32'(fetch_err),    32'h0);
        m_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int cnt, nvalid, last_v;
        bit ack_pend, req_now, a;
        rst_n = 1'b1;
        m_reset();
        do_reset();

        // Reset asserted mid-WAIT aborts the fetch.
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        check("midwait_req", 32'(mem_bus.req), 32'h1);
        do_reset();
        idle();
        check("post_rst_pc", 32'(pc), 32'h00);
        check("post_rst_ir", 32'(ir), 32'h0000);

        // Fetch from 0x10 with two wait cycles.
        set_pc(16);
        cnt = 0; nvalid = 0;
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'h0);       cnt += int'(mem_bus.req);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 0, 16'h0);       cnt += int'(mem_bus.req);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 0, 16'h0);       cnt += int'(mem_bus.req);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 1, 16'hB200);    cnt += int'(mem_bus.req);
        nvalid += int'(ir_valid);
        check("f_addr", 32'(mem_bus.addr), 32'h10);
        check("f_ir",   32'(ir), 32'hB200);
        for (int k = 0; k < 3; k++) begin idle(); nvalid += int'(ir_valid); end
        check("f_req_cycles", 32'(cnt), 32'd3);
        check("f_valid_pulses", 32'(nvalid), 32'd1);
        check("f_busy_after", 32'(busy), 32'h0);

        // Branches and wraparound.
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 1, 16'h0);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 1, 16'h77FD);
        idle();
        set_pc(5);
        cyc(0, 0, 1, 2'd1, 0, 0, 0, 0, 16'h0);
        check("bra_rel", 32'(pc), 32'h02);
        cyc(0, 0, 1, 2'd1, 1, 0, 0, 0, 16'h0);
        check("bra_abs", 32'(pc), 32'hFD);
        cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        check("pc_wrap", 32'(pc), 32'h00);

        // Stack register and strobe priority.
        set_pc(32);
        cyc(0, 0, 0, 2'd0, 0, 1, 0, 0, 16'h0);
        cyc(0, 0, 1, 2'd3, 0, 0, 0, 0, 16'h0);
        check("ld_zero", 32'(pc), 32'h00);
        cyc(0, 0, 1, 2'd2, 0, 0, 0, 0, 16'h0);
        check("ld_stack", 32'(pc), 32'h21);
        cyc(0, 0, 0, 2'd0, 0, 1, 0, 0, 16'h0);       // stack <= 0x22
        cyc(0, 1, 1, 2'd2, 0, 1, 0, 0, 16'h0);       // swap: pc 0x22, stack 0x22
        cyc(0, 1, 0, 2'd0, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 1, 2'd2, 0, 1, 0, 0, 16'h0);
        check("swap_pc", 32'(pc), 32'h22);
        cyc(1, 1, 1, 2'd1, 1, 0, 0, 0, 16'h0);
        check("prio_rst", 32'(pc), 32'h00);

        // Timeout: no ack ever.
        do_reset();
        cnt = 0;
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'h0);
        for (int k = 0; k < 20 && mem_bus.req; k++) begin
            cnt++;
            idle();
        end
        check("to_req_cycles", 32'(cnt), 32'd15);
        check("to_err",  32'(fetch_err), 32'h1);
        check("to_busy", 32'(busy), 32'h0);

        // IR_Ld during WAIT.
        do_reset();
        nvalid = 0;
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'h0);
        cyc(0, 0, 0, 2'd0, 0, 0, 1, 0, 16'h0);
        check("dbl_err", 32'(fetch_err), 32'h1);
        cyc(0, 0, 0, 2'd0, 0, 0, 0, 1, 16'h1234);    nvalid += int'(ir_valid);
        for (int k = 0; k < 4; k++) begin idle(); nvalid += int'(ir_valid); end
        check("dbl_ir", 32'(ir), 32'h1234);
        check("dbl_pulses", 32'(nvalid), 32'd1);

        // IR_Ld held high against a memory that acks one cycle after seeing req.
        do_reset();
        ack_pend = 0; nvalid = 0; last_v = -1;
        for (int k = 0; k < 12; k++) begin
            req_now = mem_bus.req;
            a = ack_pend;
            cyc(0, 0, 0, 2'd0, 0, 0, 1, a, 16'(k * 16'h0101));
            ack_pend = req_now && !a;
            if (ir_valid) begin
                if (last_v >= 0) check("b2b_period", 32'(k - last_v), 32'd3);
                last_v = k;
                nvalid++;
            end
        end
        check("b2b_pulses", 32'(nvalid), 32'd4);

        // Randomized strobes; second half uses rare acks to reach timeouts.
        for (int k = 0; k < 1600; k++) begin
            bit [15:0] d;
            if (k % 400 == 0) do_reset();
            d = 16'($urandom);
            a = (k < 800) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0), a, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
